// File: rtl/pio_debounce_capture.sv
`default_nettype none
// ============================================================================
//  Module   : pio_debounce_capture
//  Purpose  : Avalon-MM input port for switches and push-buttons. Each input
//             is synchronised, debounced with a per-bit counter and
//             edge-detected into a sticky capture register. The capture
//             register drives a maskable level interrupt. The register layout
//             matches a plain PIO input so existing drivers keep working.
//
//  Ports    : clk_clk        - sole clock
//             reset_reset_n  - asynchronous active-low reset
//             avs_address    - word address (0 stable, 1 zero, 2 mask, 3 capture)
//             avs_read       - read strobe (readdata registered, latency 1)
//             avs_write      - write strobe
//             avs_writedata  - write data
//             avs_readdata   - read data, holds between reads
//             coe_in         - raw pad inputs, asynchronous to clk_clk
//             irq            - registered level interrupt
//
//  Revision : 1.0 - initial release
// ============================================================================
module pio_debounce_capture #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    input  logic [WIDTH-1:0] coe_in,
    output logic             irq
);

    localparam int                 c_CNT_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST    = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [1:0]         c_ADDR_STABLE = 2'd0;
    localparam logic [1:0]         c_ADDR_MASK   = 2'd2;
    localparam logic [1:0]         c_ADDR_CAP    = 2'd3;

    logic [WIDTH-1:0]   w_lin;
    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_stable;
    logic [WIDTH-1:0]   w_stable_nxt;
    logic [c_CNT_W-1:0] r_cnt     [WIDTH];
    logic [c_CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0]   w_ev;
    logic [WIDTH-1:0]   r_irq_mask;
    logic [WIDTH-1:0]   r_edge_cap;
    logic [WIDTH-1:0]   w_clr;
    logic               w_mask_we;
    logic               r_irq;
    logic [31:0]        r_readdata;
    logic [31:0]        w_rdata;
    logic               w_unused;

    // Polarity is fixed before the synchroniser so everything downstream
    // sees "1 = active".
    assign w_lin = ACTIVE_LOW ? ~coe_in : coe_in;

    // Only the low WIDTH bits of the write data carry meaning.
    assign w_unused = &{1'b0, avs_writedata};

    // ------------------------------------------------------------------
    // Per-bit debounce: the counter runs only while the synchronised input
    // disagrees with the stable value; any agreement restarts it, so a
    // glitch shorter than DEBOUNCE_CYCLES never reaches the stable value.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic w_differs;
        logic w_expire;

        assign w_differs        = r_sync2[gi] ^ r_stable[gi];
        assign w_expire         = w_differs && (r_cnt[gi] == c_CNT_LAST);
        assign w_cnt_nxt[gi]    = (w_differs && !w_expire) ? (r_cnt[gi] + c_CNT_ONE) : '0;
        assign w_stable_nxt[gi] = w_expire ? r_sync2[gi] : r_stable[gi];

        // The event fires on the same edge that commits the new stable
        // value, qualified by the direction of that new value.
        if (EDGE_MODE == 0) begin : g_rise
            assign w_ev[gi] = w_expire & r_sync2[gi];
        end else if (EDGE_MODE == 1) begin : g_fall
            assign w_ev[gi] = w_expire & ~r_sync2[gi];
        end else begin : g_any
            assign w_ev[gi] = w_expire;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= w_lin;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture, mask and interrupt
    // ------------------------------------------------------------------
    assign w_clr     = (avs_write && (avs_address == c_ADDR_CAP)) ? avs_writedata[WIDTH-1:0] : '0;
    assign w_mask_we = avs_write && (avs_address == c_ADDR_MASK);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_edge_cap <= '0;
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            // A new event overrides a simultaneous write-1-to-clear.
            r_edge_cap <= w_ev | (r_edge_cap & ~w_clr);
            if (w_mask_we) begin
                r_irq_mask <= avs_writedata[WIDTH-1:0];
            end
            r_irq <= |(r_edge_cap & r_irq_mask);
        end
    end

    // ------------------------------------------------------------------
    // Read path: sampled from current register values, so a read paired
    // with a write returns the pre-write contents.
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (avs_address)
            c_ADDR_STABLE: w_rdata[WIDTH-1:0] = r_stable;
            c_ADDR_MASK:   w_rdata[WIDTH-1:0] = r_irq_mask;
            c_ADDR_CAP:    w_rdata[WIDTH-1:0] = r_edge_cap;
            default:       w_rdata            = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_readdata <= '0;
        end else if (avs_read) begin
            r_readdata <= w_rdata;
        end
    end

    assign avs_readdata = r_readdata;
    assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_pio_debounce_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pio_debounce_capture
//  Purpose  : Self-checking bench. Three instances (rising, falling, any
//             edge) share one bus and one set of pad inputs; a behavioural
//             model predicts readdata and irq of each instance every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pio_debounce_capture;

    localparam int c_W = 4;
    localparam int c_D = 4;

    logic             clk_clk       = 1'b0;
    logic             reset_reset_n = 1'b0;
    logic [1:0]       avs_address   = '0;
    logic             avs_read      = 1'b0;
    logic             avs_write     = 1'b0;
    logic [31:0]      avs_writedata = '0;
    logic [c_W-1:0]   coe_in        = '1;
    logic [2:0][31:0] dut_rd;
    logic [2:0]       dut_irq;

    int n_vec  = 0;
    int n_err  = 0;
    bit chk_on = 1'b0;

    always #5 clk_clk = ~clk_clk;

    for (genvar gm = 0; gm < 3; gm++) begin : g_dut
        pio_debounce_capture #(
            .WIDTH           (c_W),
            .DEBOUNCE_CYCLES (c_D),
            .ACTIVE_LOW      (1'b1),
            .EDGE_MODE       (gm)
        ) u_dut (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .avs_address   (avs_address),
            .avs_read      (avs_read),
            .avs_write     (avs_write),
            .avs_writedata (avs_writedata),
            .avs_readdata  (dut_rd[gm]),
            .coe_in        (coe_in),
            .irq           (dut_irq[gm])
        );
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. The stable value of a bit flips when the logical
    // input sampled at the previous D edges (seen through the two-edge
    // synchroniser delay) all disagreed with it.
    // ------------------------------------------------------------------
    logic [c_W-1:0] m_hist [$];
    logic [c_W-1:0] m_stable;
    logic [c_W-1:0] m_mask;
    logic [c_W-1:0] m_flip;
    logic [c_W-1:0] m_new;
    logic [c_W-1:0] m_clr;
    logic [c_W-1:0] m_cap [3];
    logic [c_W-1:0] m_ev  [3];
    logic [31:0]    m_rd  [3];
    logic           m_irq [3];
    bit             m_same;

    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            m_hist.delete();
            for (int k = 0; k < c_D + 2; k++) m_hist.push_back('0);
            m_stable = '0;
            m_mask   = '0;
            for (int k = 0; k < 3; k++) begin
                m_cap[k] = '0;
                m_rd[k]  = '0;
                m_irq[k] = 1'b0;
            end
        end else begin
            for (int b = 0; b < c_W; b++) begin
                m_same = 1'b0;
                for (int j = 0; j < c_D; j++) begin
                    if (m_hist[m_hist.size() - 2 - j][b] == m_stable[b]) m_same = 1'b1;
                end
                m_flip[b] = !m_same;
            end
            m_new   = m_stable ^ m_flip;
            m_ev[0] = m_flip & m_new;
            m_ev[1] = m_flip & ~m_new;
            m_ev[2] = m_flip;
            m_clr   = (avs_write && avs_address == 2'd3) ? avs_writedata[c_W-1:0] : '0;
            for (int k = 0; k < 3; k++) begin
                if (avs_read) begin
                    case (avs_address)
                        2'd0:    m_rd[k] = 32'(m_stable);
                        2'd1:    m_rd[k] = 32'd0;
                        2'd2:    m_rd[k] = 32'(m_mask);
                        default: m_rd[k] = 32'(m_cap[k]);
                    endcase
                end
                m_irq[k] = |(m_cap[k] & m_mask);
                m_cap[k] = m_ev[k] | (m_cap[k] & ~m_clr);
            end
            if (avs_write && avs_address == 2'd2) m_mask = avs_writedata[c_W-1:0];
            m_stable = m_new;
            m_hist.push_back(~coe_in);
            if (m_hist.size() > c_D + 2) void'(m_hist.pop_front());
        end
    end

    always @(negedge clk_clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                check_val($sformatf("rdata[%0d]", k), dut_rd[k], m_rd[k]);
                check_val($sformatf("irq[%0d]", k), 32'(dut_irq[k]), 32'(m_irq[k]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all driven just after a falling edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk_clk);
        avs_write     = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] addr,
                          input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge clk_clk);
        avs_read    = 1'b0;
        check_val({tag, "/rise"}, dut_rd[0], e0);
        check_val({tag, "/fall"}, dut_rd[1], e1);
        check_val({tag, "/any"},  dut_rd[2], e2);
    endtask

    task automatic irq_chk(input string tag, input logic e0, input logic e1, input logic e2);
        check_val({tag, "/rise"}, 32'(dut_irq[0]), 32'(e0));
        check_val({tag, "/fall"}, 32'(dut_irq[1]), 32'(e1));
        check_val({tag, "/any"},  32'(dut_irq[2]), 32'(e2));
    endtask

    initial begin
        chk_on = 1'b1;
        tick(3);
        irq_chk("reset_irq", 1'b0, 1'b0, 1'b0);
        check_val("reset_rdata", dut_rd[0], 32'd0);
        #2 reset_reset_n = 1'b1;
        tick(10);

        // Rising edge and interrupt: bit 0 pressed.
        wr(2'd2, 32'h1);
        coe_in = 4'hE;
        tick(6);
        irq_chk("t1_irq_pre", 1'b0, 1'b0, 1'b0);
        tick(1);
        irq_chk("t1_irq", 1'b1, 1'b0, 1'b1);
        rd_chk("t1_stable", 2'd0, 32'h1, 32'h1, 32'h1);
        rd_chk("t1_cap",    2'd3, 32'h1, 32'h0, 32'h1);

        // Glitch rejection on bit 1: 3-cycle pulse ignored, 4-cycle accepted.
        coe_in = 4'hC;
        tick(3);
        coe_in = 4'hE;
        tick(10);
        rd_chk("t2_glitch", 2'd0, 32'h1, 32'h1, 32'h1);
        rd_chk("t2_cap",    2'd3, 32'h1, 32'h0, 32'h1);
        coe_in = 4'hC;
        tick(4);
        coe_in = 4'hE;
        tick(2);
        rd_chk("t2_pulse", 2'd0, 32'h3, 32'h3, 32'h3);
        tick(10);
        rd_chk("t2_cap2", 2'd3, 32'h3, 32'h2, 32'h3);
        wr(2'd3, 32'hF);
        tick(2);

        // Masking and clearing on bit 2.
        wr(2'd2, 32'h0);
        coe_in = 4'hA;
        tick(10);
        rd_chk("t3_cap", 2'd3, 32'h4, 32'h0, 32'h4);
        irq_chk("t3_irq_masked", 1'b0, 1'b0, 1'b0);
        wr(2'd2, 32'h4);
        tick(1);
        irq_chk("t3_irq_unmask", 1'b1, 1'b0, 1'b1);
        wr(2'd3, 32'h4);
        tick(1);
        irq_chk("t3_irq_clr", 1'b0, 1'b0, 1'b0);
        rd_chk("t3_cap_clr", 2'd3, 32'h0, 32'h0, 32'h0);

        // Set/clear collision on bit 0.
        wr(2'd2, 32'h1);
        coe_in = 4'hB;
        tick(10);
        coe_in = 4'hA;
        tick(5);
        avs_address   = 2'd3;
        avs_writedata = 32'h1;
        avs_write     = 1'b1;
        tick(1);
        avs_write     = 1'b0;
        tick(1);
        irq_chk("t4_irq", 1'b1, 1'b0, 1'b1);
        rd_chk("t4_cap", 2'd3, 32'h1, 32'h0, 32'h1);

        // Edge modes: release then press of bit 0.
        wr(2'd3, 32'hF);
        coe_in = 4'hB;
        tick(10);
        rd_chk("t5_release", 2'd3, 32'h0, 32'h1, 32'h1);
        wr(2'd3, 32'h1);
        coe_in = 4'hA;
        tick(10);
        rd_chk("t5_press", 2'd3, 32'h1, 32'h0, 32'h1);

        // Reset mid-count, then re-debounce of the still-held bit 2.
        rd_chk("t6_pre", 2'd0, 32'h5, 32'h5, 32'h5);
        coe_in = 4'hB;
        tick(4);
        #2 reset_reset_n = 1'b0;
        #1;
        irq_chk("t6_irq_rst", 1'b0, 1'b0, 1'b0);
        check_val("t6_rd_rst/rise", dut_rd[0], 32'd0);
        check_val("t6_rd_rst/fall", dut_rd[1], 32'd0);
        check_val("t6_rd_rst/any",  dut_rd[2], 32'd0);
        tick(1);
        #2 reset_reset_n = 1'b1;
        tick(5);
        rd_chk("t6_before", 2'd0, 32'h0, 32'h0, 32'h0);
        rd_chk("t6_after",  2'd0, 32'h4, 32'h4, 32'h4);

        // Randomised traffic and pad activity against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) coe_in = 4'($urandom);
            avs_read      = 1'($urandom);
            avs_write     = ($urandom_range(0, 3) == 0);
            avs_address   = 2'($urandom);
            avs_writedata = $urandom;
            if (i == 1000) begin
                #2 reset_reset_n = 1'b0;
                #4 reset_reset_n = 1'b1;
            end
            @(negedge clk_clk);
        end
        avs_read  = 1'b0;
        avs_write = 1'b0;
        tick(2);
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
